// File: rtl/fpu_seq.sv
// Sequencer between execute and the single-issue FPU: accept, issue, wait out busy, writeback.
// One operation in flight at a time; a watchdog bounds the busy wait and sets a sticky err.
module fpu_seq #(
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_sel,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [31:0] req_c,
  input  logic [4:0]  req_rd,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [31:0] fpu_c,
  output logic [2:0]  fpu_sel,
  output logic        fpu_input_valid,
  input  logic [31:0] fpu_res,
  input  logic        fpu_busy,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [4:0]      rd_reg;

  assign req_ready = (state_reg == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      rd_reg          <= '0;
      fpu_a           <= '0;
      fpu_b           <= '0;
      fpu_c           <= '0;
      fpu_sel         <= '0;
      fpu_input_valid <= 1'b0;
      wb_valid        <= 1'b0;
      wb_data         <= '0;
      wb_rd           <= '0;
      err             <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            fpu_sel         <= req_sel;
            fpu_a           <= req_a;
            fpu_b           <= req_b;
            fpu_c           <= req_c;
            rd_reg          <= req_rd;
            cnt_reg         <= '0;
            fpu_input_valid <= 1'b1;
            state_reg       <= ISSUE;
          end
        end
        ISSUE: begin
          fpu_input_valid <= 1'b0;
          cnt_reg         <= CW'(1);
          // Zero-latency ops never raise busy, so their result is ready in the issue cycle.
          if (!fpu_busy) begin
            wb_data   <= fpu_res;
            wb_rd     <= rd_reg;
            wb_valid  <= 1'b1;
            state_reg <= WB;
          end else begin
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (!fpu_busy || cnt_reg == CNT_MAX) begin
            // On a watchdog expiry the result is still forwarded so the pipeline does not stall.
            if (fpu_busy) err <= 1'b1;
            wb_data   <= fpu_res;
            wb_rd     <= rd_reg;
            wb_valid  <= 1'b1;
            state_reg <= WB;
          end else if (cnt_reg != {CW{1'b1}}) begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        WB: begin
          if (wb_ready) begin
            wb_valid  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fpu_seq.md
# fpu_seq

Sequencer in front of the single-issue FPU. Accepts one FP operation per valid/ready handshake from execute, registers the operands, and pulses the FPU start. It then waits out the FPU's `busy` window, captures the result, and presents it with its destination register to writeback over a second valid/ready handshake. Only one operation is in flight at a time. A watchdog flags an FPU that never drops `busy`.

## Interface

Parameters:
- `TIMEOUT`, 8: maximum cycles from issue to capture before the watchdog fires. Legal range 5..15; the longest FPU op latency is 4.

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  execute offers an operation
- `req_ready`  out  1  sequencer can accept
- `req_sel`  in  3  FPU op select, encoded per `control_sel.vh`
- `req_a`, `req_b`, `req_c`  in  32 each  operands
- `req_rd`  in  5  destination FP register
- `fpu_a`, `fpu_b`, `fpu_c`  out  32 each  registered operands to the FPU
- `fpu_sel`  out  3  registered op select to the FPU
- `fpu_input_valid`  out  1  one-cycle start pulse
- `fpu_res`  in  32  FPU result
- `fpu_busy`  in  1  FPU busy
- `wb_valid`  out  1  result available
- `wb_ready`  in  1  writeback accepts
- `wb_data`  out  32  captured result
- `wb_rd`  out  5  destination register of `wb_data`
- `err`  out  1  sticky watchdog flag

## Operation

- States:
  - IDLE
  - ISSUE
  - WAIT
  - WB
- All outputs are registered except `req_ready`, which equals (state == IDLE).
- IDLE:
  - On `req_valid`, latch `req_sel` into `fpu_sel` and `req_a/b/c` into `fpu_a/b/c`.
  - Latch `req_rd` into the internal `rd_q`.
  - Clear the wait counter and go to ISSUE.
  - Without `req_valid`, hold every output.
- ISSUE:
  - `fpu_input_valid` = 1 for exactly this cycle.
  - Wait counter = 1.
  - If `fpu_busy` = 0 (zero-latency ops: ASEL, BSEL, SGNJ), capture `fpu_res` into `wb_data` and `rd_q` into `wb_rd`, then go to WB.
  - Otherwise go to WAIT.
- WAIT:
  - Each cycle, if `fpu_busy` = 0, capture as in ISSUE and go to WB.
  - Else, if the wait counter equals `TIMEOUT`, set `err`, capture `fpu_res` anyway and go to WB.
  - Else increment the wait counter (saturating width ceil(log2(TIMEOUT+1))).
- WB:
  - `wb_valid` = 1.
  - `wb_data` and `wb_rd` are held stable until `wb_ready` is seen.
  - On `wb_valid & wb_ready`, go to IDLE.
  - No new request is accepted in the same cycle.
- Operand hold:
  - `fpu_a/b/c` and `fpu_sel` stay constant from ISSUE through capture.
  - This is required because the FPU samples operands in several pipeline stages.
- `err` is cleared only by reset. Operation continues normally after `err` is set.
- `req_*` is ignored outside IDLE. `wb_ready` is ignored outside WB.

## Timing

- Reset values (asserted asynchronously, held while `rst` = 0):
  - state IDLE, so `req_ready` = 1
  - `fpu_input_valid` = 0, `wb_valid` = 0, `err` = 0
  - `fpu_a/b/c`, `fpu_sel`, `wb_data`, `wb_rd` all 0
  - wait counter 0
- FPU op latencies L:
  - ASEL, BSEL, SGNJ: 0
  - CVT: 1
  - ADD: 3
  - MADD: 4
- `fpu_busy` is high from the issue cycle until issue + L − 1. The result is captured at cycle issue + L.
- With the request accepted at cycle T:
  - ISSUE is at T+1.
  - Capture is at the edge ending cycle T+1+L.
  - `wb_valid` rises at T+2+L.
  - Examples: ADD gives `wb_valid` at T+5; ASEL gives it at T+2.
- Earliest next accept: with `wb_ready` held high, the cycle after the WB handshake. Back-to-back ADDs therefore sustain one op per 6 cycles.
- Watchdog: if `busy` never drops, `err` and `wb_valid` rise together at T+2+TIMEOUT.
- Reset mid-operation (any state) aborts immediately:
  - `wb_valid` and `fpu_input_valid` drop.
  - The in-flight result is discarded, with no writeback.

## Test plan

- Reset:
  - Stimulus: assert `rst` = 0 mid-WAIT of an ADD.
  - Required: all outputs return to their reset values with no clock edge needed; after release, `req_ready` = 1 and there is no `wb_valid`.
- Zero-latency op:
  - Stimulus: ASEL with a = 0x3F800000, rd = 3, accepted at T.
  - Required: one-cycle `fpu_input_valid` at T+1; `wb_valid` at T+2 with `wb_data` = 0x3F800000 and `wb_rd` = 3.
- Multi-cycle op with a behavioural FPU model:
  - Stimulus: ADD 1.0 + 2.0 (0x3F800000, 0x40000000), rd = 7.
  - Required: `fpu_a/b` stable T+1..T+4; `wb_valid` at T+5 with 0x40400000 and `wb_rd` = 7.
  - Stimulus: MADD 2.0 × 3.0 + 1.0 (a = 0x40000000, b = 0x40400000, c = 0x3F800000).
  - Required: `wb_valid` at T+6 with 0x40E00000.
- Writeback backpressure:
  - Stimulus: hold `wb_ready` = 0 for 5 cycles after `wb_valid`, while `req_valid` stays high with a new op.
  - Required: `wb_data`/`wb_rd` are stable throughout; `req_ready` = 0; the new op is accepted only the cycle after the handshake.
- Watchdog:
  - Stimulus: hold `fpu_busy` = 1 with TIMEOUT = 8.
  - Required: `err` = 1 and `wb_valid` = 1 at T+10; `err` stays set through subsequent normal ops until reset.
- Back-to-back:
  - Stimulus: 4 random ops with random rd and `wb_ready` tied high.
  - Required: results in order, rd matching each op, exactly one `fpu_input_valid` pulse per op.
